fg_output_stage: RTL and testbench

Pipelined output stage of the function generator, placed between the waveform channels and the DAC interface. It selects one of DATA_COUNT signed sample streams, scales it by a programmable gain, adds a signed offset and saturates the result to BITWIDTH. Channel changes take effect only on a waveform period boundary, so the output never glitches mid-period. Sticky clip flag and enable gating are included.

---
 rtl/fg_pkg.sv | 18 +
 rtl/fg_sat_add.sv | 36 +++
 rtl/fg_output_stage.sv | 127 ++++++++++++
 tb/tb_fg_output_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fg_pkg.sv
// Shared types and constants for the function generator output path.
// Imported by the output stage and its saturating adder.
package fg_pkg;

  localparam int FG_DATA_COUNT = 3;
  localparam int SEL_W = $clog2(FG_DATA_COUNT);

  typedef enum logic [1:0] {
    DISABLED,
    RUN,
    PENDING
  } fg_state_e;

  function automatic int unity_gain(input int gain_w);
    return 1 << (gain_w - 1);
  endfunction

endpackage

// File: rtl/fg_sat_add.sv
// Sign-extended add of a wide value and a narrow offset, saturated
// to OUT_W bits with a clip indicator.
module fg_sat_add #(
  parameter int IN_W  = 25,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  a_i,
  input  logic signed [OUT_W-1:0] b_i,
  output logic [OUT_W-1:0]        sum_o,
  output logic                    clip_o
);

  localparam int SW = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] maxv;
  logic signed [SW-1:0] minv;

  assign sum  = {{(SW-IN_W){a_i[IN_W-1]}}, a_i}
              + {{(SW-OUT_W){b_i[OUT_W-1]}}, b_i};
  assign maxv = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  assign minv = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    sum_o  = sum[OUT_W-1:0];
    clip_o = 1'b0;
    if (sum > maxv) begin
      sum_o  = {1'b0, {(OUT_W-1){1'b1}}};
      clip_o = 1'b1;
    end else if (sum < minv) begin
      sum_o  = {1'b1, {(OUT_W-1){1'b0}}};
      clip_o = 1'b1;
    end
  end

endmodule

// File: rtl/fg_output_stage.sv
// Output stage: channel select on period boundaries, gain, offset,
// saturation and enable gating, three-clock pipeline.
module fg_output_stage
  import fg_pkg::*;
#(
  parameter int BITWIDTH   = 16,
  parameter int DATA_COUNT = 3,
  parameter int GAIN_WIDTH = 8
) (
  input  logic                           clk_i,
  input  logic                           nrst_i,
  input  logic                           enable_i,
  input  logic [$clog2(DATA_COUNT)-1:0]  select_i,
  input  logic [GAIN_WIDTH-1:0]          gain_i,
  input  logic [BITWIDTH-1:0]            offset_i,
  input  logic [DATA_COUNT*BITWIDTH-1:0] data_i,
  input  logic                           valid_i,
  input  logic                           period_start_i,
  input  logic                           clear_clip_i,
  output logic [BITWIDTH-1:0]            out_o,
  output logic                           valid_o,
  output logic [$clog2(DATA_COUNT)-1:0]  active_sel_o,
  output logic                           pending_o,
  output logic                           clip_o
);

  localparam int SW    = $clog2(DATA_COUNT);
  localparam int PW    = BITWIDTH + GAIN_WIDTH + 1;
  localparam int SHIFT = GAIN_WIDTH - 1;
  localparam logic [SW:0] CNT = (SW+1)'(DATA_COUNT);

  fg_state_e state_q, state_d;
  logic [SW-1:0] act_q, act_d, eff;
  logic          sel_ok, sw;

  logic signed [BITWIDTH-1:0] s1_q, s1_d;
  logic signed [PW-1:0]       s2_q, s1_ext, g_ext, prod;
  logic [BITWIDTH-1:0]        out_q, sat;
  logic                       sat_clip;
  logic                       v1_q, v2_q, v3_q, clip_q;

  assign sel_ok = ({1'b0, select_i} < CNT);

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    sw      = 1'b0;
    unique case (state_q)
      DISABLED: begin
        if (sel_ok) act_d = select_i;
        if (enable_i) state_d = RUN;
      end
      RUN: begin
        if (!enable_i) state_d = DISABLED;
        else if (sel_ok && select_i != act_q) state_d = PENDING;
      end
      PENDING: begin
        if (!enable_i) begin
          state_d = DISABLED;
        end else if (sel_ok && select_i == act_q) begin
          state_d = RUN;
        end else if (sel_ok && valid_i && period_start_i) begin
          sw      = 1'b1;
          act_d   = select_i;
          state_d = RUN;
        end
      end
      default: state_d = DISABLED;
    endcase
  end

  // The boundary sample already takes the newly requested channel.
  assign eff = sw ? select_i : act_q;

  always_comb begin
    s1_d = '0;
    for (int k = 0; k < DATA_COUNT; k++) begin
      if (eff == SW'(k)) s1_d = data_i[k*BITWIDTH +: BITWIDTH];
    end
  end

  assign s1_ext = {{(PW-BITWIDTH){s1_q[BITWIDTH-1]}}, s1_q};
  assign g_ext  = {{(PW-GAIN_WIDTH){1'b0}}, gain_i};
  assign prod   = s1_ext * g_ext;

  fg_sat_add #(
    .IN_W  (PW),
    .OUT_W (BITWIDTH)
  ) u_sat (
    .a_i    (s2_q),
    .b_i    (offset_i),
    .sum_o  (sat),
    .clip_o (sat_clip)
  );

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= DISABLED;
      act_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      out_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      v1_q    <= valid_i;
      v2_q    <= v1_q;
      v3_q    <= v2_q;
      if (valid_i) s1_q <= s1_d;
      if (v1_q) s2_q <= prod >>> SHIFT;
      if (v2_q) out_q <= enable_i ? sat : '0;
      if (v2_q && enable_i && sat_clip) clip_q <= 1'b1;
      else if (clear_clip_i) clip_q <= 1'b0;
    end
  end

  assign out_o        = out_q;
  assign valid_o      = v3_q;
  assign active_sel_o = act_q;
  assign pending_o    = (state_q == PENDING);
  assign clip_o       = clip_q;

endmodule

// File: tb/tb_fg_output_stage.sv
// Randomized bench for fg_output_stage against a behavioural model,
// plus directed literal checks.
module tb_fg_output_stage;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [7:0]  gain = 8'd128;
  logic [15:0] offset = 16'd0;
  logic [15:0] ch [3];
  logic [47:0] data;
  logic        valid = 1'b0;
  logic        ps = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] out_o;
  logic        valid_o;
  logic [1:0]  act_o;
  logic        pend_o;
  logic        clip_o;

  int n_cmp = 0;
  int n_err = 0;

  assign data = {ch[2], ch[1], ch[0]};

  fg_output_stage #(
    .BITWIDTH   (16),
    .DATA_COUNT (3),
    .GAIN_WIDTH (8)
  ) dut (
    .clk_i          (clk),
    .nrst_i         (nrst),
    .enable_i       (en),
    .select_i       (sel),
    .gain_i         (gain),
    .offset_i       (offset),
    .data_i         (data),
    .valid_i        (valid),
    .period_start_i (ps),
    .clear_clip_i   (clr),
    .out_o          (out_o),
    .valid_o        (valid_o),
    .active_sel_o   (act_o),
    .pending_o      (pend_o),
    .clip_o         (clip_o)
  );

  always #5 clk = ~clk;

  // Reference model: disabled/pending flags, active channel, and the
  // in-flight samples computed with plain integer arithmetic.
  bit     m_dis = 1'b1, m_pend = 1'b0, m_clip = 1'b0;
  bit     m_v1 = 1'b0, m_v2 = 1'b0, m_v3 = 1'b0;
  int     m_act = 0, m_s1 = 0, m_out = 0;
  longint m_s2 = 0;

  always @(posedge clk or negedge nrst) begin
    int  sum, satv, eff;
    bit  ok, setc;
    if (!nrst) begin
      m_dis = 1'b1; m_pend = 1'b0; m_act = 0;
      m_s1 = 0; m_s2 = 0; m_out = 0;
      m_v1 = 1'b0; m_v2 = 1'b0; m_v3 = 1'b0; m_clip = 1'b0;
    end else begin
      setc = 1'b0;
      m_v3 = m_v2;
      if (m_v2) begin
        sum  = int'(m_s2) + int'($signed(offset));
        satv = (sum > 32767) ? 32767 : (sum < -32768) ? -32768 : sum;
        setc = en && (satv != sum);
        m_out = en ? satv : 0;
      end
      if (m_v1) m_s2 = (longint'(m_s1) * longint'(gain)) >>> 7;
      m_v2 = m_v1;
      ok  = (sel < 2'd3);
      eff = m_act;
      if (m_dis) begin
        if (ok) m_act = sel;
        m_dis  = !en;
        m_pend = 1'b0;
      end else if (!en) begin
        m_dis = 1'b1; m_pend = 1'b0;
      end else if (!m_pend) begin
        if (ok && sel != m_act) m_pend = 1'b1;
      end else if (ok && sel == m_act) begin
        m_pend = 1'b0;
      end else if (ok && valid && ps) begin
        eff = sel; m_act = sel; m_pend = 1'b0;
      end
      if (valid) m_s1 = int'($signed(ch[eff]));
      m_v1 = valid;
      if (setc) m_clip = 1'b1;
      else if (clr) m_clip = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [15:0] e_out;
    logic [1:0]  e_act;
    e_out = m_out[15:0];
    e_act = m_act[1:0];
    n_cmp++;
    if (out_o !== e_out || valid_o !== m_v3 || act_o !== e_act ||
        pend_o !== m_pend || clip_o !== m_clip) begin
      n_err++;
      $display("FAIL model t=%0t out=%h/%h v=%b/%b sel=%0d/%0d pend=%b/%b clip=%b/%b",
               $time, out_o, e_out, valid_o, m_v3, act_o, e_act,
               pend_o, m_pend, clip_o, m_clip);
    end
  end

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    ch[0] = 16'd0; ch[1] = 16'd0; ch[2] = 16'd0;
    sel = 2'd1;
    tick(3);
    nrst = 1'b1;
    tick(2);
    chk("rst_out", out_o, 16'h0);
    chk("rst_act", {14'd0, act_o}, 16'd1);

    // 1: unity gain passthrough with 3-clock latency
    en = 1'b1; ch[1] = 16'h1234; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    chk("t1_v_early", {15'd0, valid_o}, 16'd0);
    tick();
    chk("t1_valid", {15'd0, valid_o}, 16'd1);
    chk("t1_out", out_o, 16'h1234);
    chk("t1_clip", {15'd0, clip_o}, 16'd0);
    tick();

    // 2: positive and negative saturation with clip clear
    en = 1'b0; sel = 2'd0;
    tick(2);
    en = 1'b1; tick();
    ch[0] = 16'h7000; gain = 8'd255; offset = 16'h2000; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick(2);
    chk("t2_pos", out_o, 16'h7FFF);
    chk("t2_clip", {15'd0, clip_o}, 16'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t2_clr", {15'd0, clip_o}, 16'd0);
    ch[0] = 16'h9000; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick(2);
    chk("t2_neg", out_o, 16'h8000);
    chk("t2_clip2", {15'd0, clip_o}, 16'd1);
    clr = 1'b1; tick(); clr = 1'b0;

    // 3: channel change waits for the period boundary
    gain = 8'd128; offset = 16'd0; ch[0] = 16'h0111; ch[2] = 16'h0555;
    sel = 2'd2; tick();
    chk("t3_pend", {15'd0, pend_o}, 16'd1);
    chk("t3_keep", {14'd0, act_o}, 16'd0);
    valid = 1'b1; tick();
    ps = 1'b1; tick();
    valid = 1'b0; ps = 1'b0;
    chk("t3_act", {14'd0, act_o}, 16'd2);
    chk("t3_pend0", {15'd0, pend_o}, 16'd0);
    tick();
    chk("t3_old", out_o, 16'h0111);
    tick();
    chk("t3_new", out_o, 16'h0555);

    // 4: disable with a running stream, then re-enable
    valid = 1'b1; tick(2);
    en = 1'b0; tick(4);
    chk("t4_zero", out_o, 16'h0);
    chk("t4_vld", {15'd0, valid_o}, 16'd1);
    sel = 2'd1; tick();
    chk("t4_sel", {14'd0, act_o}, 16'd1);
    en = 1'b1; tick(4);
    chk("t4_nopend", {15'd0, pend_o}, 16'd0);
    valid = 1'b0;

    // 5: out-of-range select is ignored
    sel = 2'd3; tick(2);
    chk("t5_act", {14'd0, act_o}, 16'd1);
    chk("t5_pend", {15'd0, pend_o}, 16'd0);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 3; k++) ch[k] = 16'($urandom);
      valid  = ($urandom_range(0, 9) < 7);
      ps     = ($urandom_range(0, 4) == 0);
      clr    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 7) == 0) gain = 8'($urandom);
      if ($urandom_range(0, 7) == 0)
        offset = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
      tick();
    end

    // 6: reset while pending with samples in flight
    valid = 1'b0; ps = 1'b0; clr = 1'b0; en = 1'b1; sel = 2'd0;
    tick(2);
    sel = 2'd1; tick();
    chk("t6_pend", {15'd0, pend_o}, 16'd1);
    valid = 1'b1; tick(2);
    nrst = 1'b0; #1;
    chk("t6_out", out_o, 16'h0);
    chk("t6_vld", {15'd0, valid_o}, 16'd0);
    chk("t6_pnd", {15'd0, pend_o}, 16'd0);
    chk("t6_act", {14'd0, act_o}, 16'd0);
    valid = 1'b0; en = 1'b0;
    tick(2);
    nrst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("t6_flush", {15'd0, valid_o}, 16'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
